// File: rtl/mul_unit_if.sv
// Request/result bundle between the execute-stage controller and mul_unit.
// Latency: none, wires only.
// Backpressure: valid/ready on both the request and the result side.
// Ports (by modport):
//   master : drives in_valid, A, B, MulSel, out_ready; observes in_ready, out_valid, MulRes
//   slave  : the multiplier side, mirror image of master
interface mul_unit_if #(parameter int N = 32);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [1:0]   MulSel;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] MulRes;

  modport master (
    output in_valid, A, B, MulSel, out_ready,
    input  in_ready, out_valid, MulRes
  );

  modport slave (
    input  in_valid, A, B, MulSel, out_ready,
    output in_ready, out_valid, MulRes
  );
endinterface

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for mul/mulh/mulhsu/mulhu.
// Latency: result valid N+1 edges after the acceptance edge, independent of operands.
// Backpressure: result held in DONE until out_ready; no request accepted outside IDLE.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of mul_unit_if (request A/B/MulSel, result MulRes)
module mul_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  mul_unit_if.slave    bus
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [N-1:0]   res_q, res_d;
  logic [1:0]     sel_q, sel_d;
  logic           neg_q, neg_d;
  logic           ovld_q, ovld_d;

  logic           a_neg, b_neg;
  logic [N:0]     sum;
  logic [2*N-1:0] prod_fix;

  always_comb begin
    // rs1 is signed for mulh/mulhsu, rs2 only for mulh
    a_neg    = ((bus.MulSel == 2'b01) || (bus.MulSel == 2'b10)) && bus.A[N-1];
    b_neg    = (bus.MulSel == 2'b01) && bus.B[N-1];
    // N+1 bits so the carry out of the upper half survives the shift
    sum      = {1'b0, prod_q[2*N-1:N]} + {1'b0, mcand_q & {N{mplier_q[0]}}};
    prod_fix = neg_q ? (~prod_q + (2*N)'(1)) : prod_q;

    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    res_d    = res_q;
    sel_d    = sel_q;
    neg_d    = neg_q;
    ovld_d   = ovld_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // two's-complement magnitude; 0x80..0 maps to itself, which is correct unsigned
          mcand_d  = a_neg ? (~bus.A + N'(1)) : bus.A;
          mplier_d = b_neg ? (~bus.B + N'(1)) : bus.B;
          neg_d    = a_neg ^ b_neg;
          sel_d    = bus.MulSel;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        prod_d   = {sum, prod_q[N-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        prod_d  = prod_fix;
        res_d   = (sel_q == 2'b00) ? prod_fix[N-1:0] : prod_fix[2*N-1:N];
        ovld_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          ovld_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      res_q    <= '0;
      sel_q    <= '0;
      neg_q    <= 1'b0;
      ovld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      res_q    <= res_d;
      sel_q    <= sel_d;
      neg_q    <= neg_d;
      ovld_q   <= ovld_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = ovld_q;
  assign bus.MulRes    = res_q;
endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corner cases plus random ops vs a 64-bit arithmetic model.
// Latency: every op is checked for the fixed 33-cycle acceptance-to-valid latency.
// Backpressure: results are held with out_ready low while bogus requests are offered.
module tb_mul_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mul_unit_if #(.N(32)) bus_i ();

  mul_unit #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics from full-width 64-bit products.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] sel);
    longint     sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (sel)
      2'b01:   p = 64'(sa * sb);
      2'b10:   p = 64'(sa * ub);
      default: p = {32'b0, a} * {32'b0, b};
    endcase
    return (sel == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = 32'h0000_0000;
      1:       v = 32'h0000_0001;
      2:       v = 32'h8000_0000;
      3:       v = 32'hFFFF_FFFF;
      4:       v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Starts and ends 1 time unit after a rising edge, with the unit idle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                        input logic [31:0] exp, input int hold);
    int          lat;
    logic        busy_ready;
    logic [31:0] held;
    chk("in_ready_idle", {31'b0, bus_i.in_ready}, 32'd1);
    bus_i.in_valid = 1'b1;
    bus_i.A        = a;
    bus_i.B        = b;
    bus_i.MulSel   = sel;
    bus_i.out_ready = 1'b0;
    @(posedge clk); #1;
    bus_i.in_valid = 1'b0;
    lat = 0;
    busy_ready = 1'b0;
    while (!bus_i.out_valid && lat < 100) begin
      if (bus_i.in_ready) busy_ready = 1'b1;
      // operands must have been captured at acceptance
      bus_i.A      = $urandom;
      bus_i.B      = $urandom;
      bus_i.MulSel = 2'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd33);
    chk("in_ready_busy", {31'b0, busy_ready}, 32'd0);
    chk("result", bus_i.MulRes, exp);
    held = bus_i.MulRes;
    for (int i = 0; i < hold; i++) begin
      bus_i.in_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, bus_i.out_valid}, 32'd1);
      chk("hold_ready", {31'b0, bus_i.in_ready}, 32'd0);
      chk("hold_stable", bus_i.MulRes, held);
    end
    // request offered in the consume cycle must not be taken
    bus_i.in_valid  = 1'b1;
    bus_i.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_i.in_valid  = 1'b0;
    bus_i.out_ready = 1'b0;
    chk("consume_valid", {31'b0, bus_i.out_valid}, 32'd0);
    chk("consume_in_ready", {31'b0, bus_i.in_ready}, 32'd1);
    chk("res_kept", bus_i.MulRes, held);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [1:0]  sel;
    bus_i.in_valid  = 1'b0;
    bus_i.A         = '0;
    bus_i.B         = '0;
    bus_i.MulSel    = '0;
    bus_i.out_ready = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, bus_i.in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, bus_i.out_valid}, 32'd0);
    chk("rst_mulres", bus_i.MulRes, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'd7,          32'hFFFF_FFFD, 2'b00, 32'hFFFF_FFEB, 0);
    run_op(32'h8000_0000,  32'h8000_0000, 2'b01, 32'h4000_0000, 0);
    run_op(32'hFFFF_FFFF,  32'hFFFF_FFFF, 2'b01, 32'h0000_0000, 0);
    run_op(32'hFFFF_FFFF,  32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFF, 0);
    run_op(32'hFFFF_FFFF,  32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE, 10);
    run_op(32'h1234_5678,  32'h9ABC_DEF0, 2'b11, 32'h0B00_EA4E, 0);

    // abort in the middle of the iterations
    bus_i.in_valid = 1'b1;
    bus_i.A        = 32'hDEAD_BEEF;
    bus_i.B        = 32'h1357_9BDF;
    bus_i.MulSel   = 2'b11;
    @(posedge clk); #1;
    bus_i.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_in_ready", {31'b0, bus_i.in_ready}, 32'd1);
    chk("abort_out_valid", {31'b0, bus_i.out_valid}, 32'd0);
    chk("abort_mulres", bus_i.MulRes, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    run_op(32'd3, 32'd5, 2'b00, 32'd15, 0);

    for (int n = 0; n < 40; n++) begin
      a   = pick_operand();
      b   = pick_operand();
      sel = 2'($urandom);
      run_op(a, b, sel, ref_mul(a, b, sel), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Iterative radix-2 shift-add multiplier for the RV32M multiply group (mul, mulh, mulhsu, mulhu).
- Takes the multiply operations the single-cycle integer ALU does not implement.
- Sits beside the ALU in the execute stage. The pipeline controller drives it with a valid/ready request and stalls until the result handshake completes.
- Produces one result per request. A new request is accepted only after the previous result has been consumed.

Parameters:
- N, 32, operand and result width in bits. The counter width is the ceiling of log2(N) bits, plus one bit.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request (high only in IDLE)
- A  input  N  multiplicand (rs1)
- B  input  N  multiplier (rs2)
- MulSel  input  2  operation: 00 mul, 01 mulh, 10 mulhsu, 11 mulhu (funct3[1:0])
- out_valid  output  1  MulRes valid
- out_ready  input  1  consumer accepts result
- MulRes  output  N  registered result

Behaviour:
- Clock and reset:
  - One clock domain: clk.
  - rst is asynchronous and active-high. Assertion forces state IDLE, counter 0, product/operand registers 0, MulRes 0, out_valid 0.
  - in_ready is 1 immediately while rst is high and after reset.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - CALC: N iterations.
  - SIGN: sign correction and result select.
  - DONE: out_valid=1.
- Acceptance edge (IDLE, in_valid & in_ready), which latches:
  - |A| if A is signed for the op (mulh, mulhsu) and A[N-1]=1, else A.
  - |B| if B is signed (mulh only) and B[N-1]=1, else B.
  - neg flag = XOR of the signs of the signed operands.
  - MulSel.
  - Clears the 2N-bit product and the counter, then goes to CALC.
- A, B and MulSel are sampled only on the acceptance edge. Later changes have no effect.
- CALC, each edge:
  - If the current multiplier LSB is 1, add the multiplicand to the upper N+1 bits of the product.
  - Shift right by one; increment the counter.
  - After the N-th iteration edge (counter reaches N-1), go to SIGN.
- SIGN, one edge:
  - If neg, replace the product with its two's complement over 2N bits.
  - MulRes <= product[N-1:0] for mul, else product[2N-1:N].
  - out_valid <= 1; go to DONE.
- Latency: the acceptance edge is E0. MulRes and out_valid become valid after edge E(N+1), i.e. 33 cycles for N=32. Latency is fixed and independent of the operand values.
- DONE:
  - MulRes and out_valid are held stable while out_ready=0.
  - On an edge with out_valid & out_ready, out_valid <= 0 and the state goes to IDLE.
  - MulRes keeps its last value until the next SIGN.
- Back-to-back: no new request is accepted in the same cycle the result is consumed. The earliest next acceptance is the cycle after.
- in_valid outside IDLE is ignored. No request is queued.
- Reset mid-operation (CALC, SIGN or DONE): the operation is aborted and the result is discarded. Outputs take their reset values.
- Arithmetic:
  - The unsigned accumulate uses an (N+1)-bit sum to keep the carry.
  - Magnitude of the most-negative value (0x80000000) is 0x80000000 unsigned. This is correct without special-casing.
  - Multiply by 0 yields 0 with neg forced irrelevant (the negation of 0 is 0).

Test Plan:
- mul: A=7, B=0xFFFFFFFD, MulSel=00 -> MulRes=0xFFFFFFEB. out_valid rises exactly 33 cycles after acceptance. in_ready=0 throughout.
- mulh: A=B=0x80000000 -> MulRes=0x40000000. mulh: A=0xFFFFFFFF, B=0xFFFFFFFF -> 0x00000000.
- mulhsu: A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF. mulhu with the same operands -> 0xFFFFFFFE.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. MulRes stays stable and a concurrent in_valid is not accepted. Then raise out_ready: out_valid drops next edge, in_ready=1 the cycle after.
- Reset mid-CALC: assert rst asynchronously at iteration 12 (between edges). Outputs zero immediately and in_ready=1. A new request (mul 3, 5) returns 15 with normal latency.
- Operand change: change A and B every cycle after acceptance of mulhu(0x12345678, 0x9ABCDEF0). MulRes=0x0B00EA4E, unaffected by the changes.
